// File: rtl/palette_lut_dp_if.sv
// Bus bundle for the palette RAM: CPU Avalon-MM slave side, swap control and pixel lookup.
// The master modport is the system (CPU/video timing) view, slave is the palette itself.
interface palette_lut_dp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] address;
   logic [BE_WIDTH-1:0]   byteenable;
   logic                  chipselect;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  clken;
   logic                  reset_req;
   logic                  swap_req;
   logic                  vsync;
   logic                  swap_pending;
   logic                  front_bank;
   logic                  pix_valid;
   logic [ADDR_WIDTH-1:0] pix_index;
   logic [DATA_WIDTH-1:0] pix_data;
   logic                  pix_data_valid;

   modport master (
      output address, byteenable, chipselect, write, writedata, clken, reset_req,
      output swap_req, vsync, pix_valid, pix_index,
      input  readdata, swap_pending, front_bank, pix_data, pix_data_valid
   );

   modport slave (
      input  address, byteenable, chipselect, write, writedata, clken, reset_req,
      input  swap_req, vsync, pix_valid, pix_index,
      output readdata, swap_pending, front_bank, pix_data, pix_data_valid
   );
endinterface

// File: rtl/palette_lut_dp.sv
// Double-buffered palette RAM: CPU port works on the back bank, pixel port reads the front bank,
// and a requested bank swap is deferred to the next vsync so a frame never mixes palettes.
module palette_lut_dp #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 6,
   parameter int DOUBLE_BUFFER = 1,
   parameter     INIT_FILE     = "palette.mif"
) (
   input  logic              clk,
   input  logic              reset,
   palette_lut_dp_if.slave   bus
);
   localparam int LANES  = DATA_WIDTH / 8;
   localparam int RAM_AW = ADDR_WIDTH + DOUBLE_BUFFER;
   localparam int DEPTH  = 1 << RAM_AW;

   // Bank 0 occupies the lower half, so the init file naturally lands in bank 0.
   (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  front_q;
   logic [RAM_AW-1:0]     cpu_addr;
   logic [RAM_AW-1:0]     pix_addr;
   logic                  cpu_en;
   logic                  cpu_we;
   logic [DATA_WIDTH-1:0] readdata_q;
   logic [DATA_WIDTH-1:0] s1_data_q;
   logic                  s1_valid_q;
   logic [DATA_WIDTH-1:0] pix_data_q;
   logic                  pix_data_valid_q;

   assign cpu_en = bus.clken & ~bus.reset_req;
   assign cpu_we = cpu_en & bus.chipselect & bus.write;

   generate
      if (DOUBLE_BUFFER != 0) begin : g_double
         typedef enum logic {IDLE, PENDING} state_t;
         state_t state_q;

         assign cpu_addr         = {~front_q, bus.address};
         assign pix_addr         = {front_q, bus.pix_index};
         assign bus.swap_pending = (state_q == PENDING);

         always_ff @(posedge clk) begin
            if (reset) begin
               state_q <= IDLE;
               front_q <= 1'b0;
            end else begin
               case (state_q)
                  IDLE: begin
                     if (bus.swap_req) begin
                        if (bus.vsync) front_q <= ~front_q;
                        else           state_q <= PENDING;
                     end
                  end
                  PENDING: begin
                     // Further swap_req pulses here are absorbed: one vsync, one flip.
                     if (bus.vsync) begin
                        state_q <= IDLE;
                        front_q <= ~front_q;
                     end
                  end
                  default: state_q <= IDLE;
               endcase
            end
         end
      end else begin : g_single
         assign cpu_addr         = bus.address;
         assign pix_addr         = bus.pix_index;
         assign front_q          = 1'b0;
         assign bus.swap_pending = 1'b0;
      end
   endgenerate

   assign bus.front_bank = front_q;

   // Port A: CPU byte-enabled write.
   always_ff @(posedge clk) begin
      if (cpu_we) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.byteenable[i]) mem[cpu_addr][i*8 +: 8] <= bus.writedata[i*8 +: 8];
         end
      end
   end

   // Port A read: old data on a same-address write, held while the CPU port is disabled.
   always_ff @(posedge clk) begin
      if (reset)       readdata_q <= '0;
      else if (cpu_en) readdata_q <= mem[cpu_addr];
   end

   // Port B stage 1: the bank is latched here, so in-flight lookups survive a swap.
   always_ff @(posedge clk) begin
      s1_data_q <= mem[pix_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q       <= 1'b0;
         pix_data_q       <= '0;
         pix_data_valid_q <= 1'b0;
      end else begin
         s1_valid_q       <= bus.pix_valid;
         pix_data_valid_q <= s1_valid_q;
         if (s1_valid_q) pix_data_q <= s1_data_q;
      end
   end

   assign bus.readdata       = readdata_q;
   assign bus.pix_data       = pix_data_q;
   assign bus.pix_data_valid = pix_data_valid_q;
endmodule

// File: tb/tb_palette_lut_dp.sv
// Bench for palette_lut_dp: a double-buffered and a single-bank instance, CPU vector table,
// pixel lookups scored through per-instance queues with exact latency, and swap corner sequences.
module tb_palette_lut_dp;
   localparam int DW = 32;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   palette_lut_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
   palette_lut_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

   palette_lut_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DOUBLE_BUFFER(1), .INIT_FILE("palette.mif"))
      dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   palette_lut_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DOUBLE_BUFFER(0), .INIT_FILE("palette.mif"))
      dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] m1 [2][64];
   logic [31:0] m0 [64];
   int fb_m = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } pix_exp_t;
   pix_exp_t q1[$];
   pix_exp_t q0[$];

   typedef struct {
      logic [5:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   function automatic logic [31:0] initval(input int b, input int i);
      return 32'hB000_0000 | (32'(b) << 24) | (32'(i) << 8);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr1(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
      bus1.address = a; bus1.byteenable = be; bus1.writedata = d;
      bus1.chipselect = 1'b1; bus1.write = 1'b1;
      for (int i = 0; i < 4; i++) if (be[i]) m1[1-fb_m][a][i*8 +: 8] = d[i*8 +: 8];
      tick();
      bus1.chipselect = 1'b0; bus1.write = 1'b0;
   endtask

   task automatic cpu_rd1(input logic [5:0] a, input string name, input logic [31:0] exp);
      bus1.address = a; bus1.chipselect = 1'b1; bus1.write = 1'b0;
      tick();
      bus1.chipselect = 1'b0;
      check(name, bus1.readdata, exp);
   endtask

   task automatic pix1(input logic [5:0] idx);
      bus1.pix_valid = 1'b1; bus1.pix_index = idx;
      q1.push_back('{m1[fb_m][idx], cyc + 2});
      tick();
      bus1.pix_valid = 1'b0;
   endtask

   // Pixel scoreboards: an expected entry must appear exactly at its due cycle.
   always @(negedge clk) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
         check("pix1 valid", {31'd0, bus1.pix_data_valid}, 32'd1);
         check("pix1 data", bus1.pix_data, q1[0].data);
         void'(q1.pop_front());
      end else if (bus1.pix_data_valid === 1'b1) begin
         n_checks++; n_errors++;
         $display("FAIL pix1 unexpected valid: got 1, expected 0");
      end
   end

   always @(negedge clk) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
         check("pix0 valid", {31'd0, bus0.pix_data_valid}, 32'd1);
         check("pix0 data", bus0.pix_data, q0[0].data);
         void'(q0.pop_front());
      end else if (bus0.pix_data_valid === 1'b1) begin
         n_checks++; n_errors++;
         $display("FAIL pix0 unexpected valid: got 1, expected 0");
      end
   end

   initial begin
      vecs[0] = '{6'd3,  4'hF, 32'h11223344, 32'h11223344};
      vecs[1] = '{6'd3,  4'h5, 32'hAABBCCDD, 32'h11BB33DD};
      vecs[2] = '{6'd10, 4'hF, 32'h01020304, 32'h01020304};
      vecs[3] = '{6'd10, 4'hA, 32'hFFEEDDCC, 32'hFF02DD04};
      vecs[4] = '{6'd63, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[5] = '{6'd63, 4'h0, 32'h12345678, 32'hCAFEF00D};
      vecs[6] = '{6'd0,  4'h3, 32'h0000BEEF, 32'hB100BEEF};
      vecs[7] = '{6'd1,  4'hC, 32'h98765432, 32'h98760100};

      {bus1.address, bus1.byteenable, bus1.chipselect, bus1.write, bus1.writedata} = '0;
      {bus1.reset_req, bus1.swap_req, bus1.vsync, bus1.pix_valid, bus1.pix_index} = '0;
      {bus0.address, bus0.byteenable, bus0.chipselect, bus0.write, bus0.writedata} = '0;
      {bus0.reset_req, bus0.swap_req, bus0.vsync, bus0.pix_valid, bus0.pix_index} = '0;
      bus1.clken = 1'b1; bus0.clken = 1'b1;

      reset = 1'b1;
      tick(); tick();
      check("reset readdata", bus1.readdata, 32'd0);
      check("reset pix_data", bus1.pix_data, 32'd0);
      check("reset pix_data_valid", {31'd0, bus1.pix_data_valid}, 32'd0);
      check("reset swap_pending", {31'd0, bus1.swap_pending}, 32'd0);
      check("reset front_bank", {31'd0, bus1.front_bank}, 32'd0);
      reset = 1'b0;
      tick();

      // Fill bank 1, swap, fill bank 0 (entry 5 = 0x00FF8040), swap back.
      for (int i = 0; i < 64; i++) cpu_wr1(6'(i), 4'hF, initval(1, i));
      bus1.swap_req = 1'b1; bus1.vsync = 1'b1; tick(); bus1.swap_req = 1'b0; bus1.vsync = 1'b0;
      fb_m = 1;
      for (int i = 0; i < 64; i++) cpu_wr1(6'(i), 4'hF, (i == 5) ? 32'h00FF8040 : initval(0, i));
      bus1.swap_req = 1'b1; bus1.vsync = 1'b1; tick(); bus1.swap_req = 1'b0; bus1.vsync = 1'b0;
      fb_m = 0;
      check("front after init", {31'd0, bus1.front_bank}, 32'd0);
      cpu_rd1(6'd0, "read bank1 entry0", 32'hB1000000);

      reset = 1'b1; tick(); reset = 1'b0;
      check("reset clears readdata", bus1.readdata, 32'd0);
      pix1(6'd5);
      tick(); tick(); tick();

      for (int v = 0; v < 8; v++) begin
         cpu_wr1(vecs[v].addr, vecs[v].be, vecs[v].wdata);
         cpu_rd1(vecs[v].addr, $sformatf("vec%0d read", v), vecs[v].exp);
      end
      pix1(6'd3);
      tick(); tick(); tick();

      cpu_wr1(6'd20, 4'hF, 32'h12345678);
      check("read-during-write old", bus1.readdata, 32'hB1001400);
      cpu_rd1(6'd20, "read after write", 32'h12345678);

      cpu_rd1(6'd10, "read before gated", 32'hFF02DD04);
      bus1.address = 6'd3; bus1.byteenable = 4'hF; bus1.writedata = 32'hDEADBEEF;
      bus1.chipselect = 1'b1; bus1.write = 1'b1; bus1.clken = 1'b0;
      tick();
      check("clken=0 readdata held", bus1.readdata, 32'hFF02DD04);
      bus1.clken = 1'b1; bus1.reset_req = 1'b1;
      tick();
      check("reset_req readdata held", bus1.readdata, 32'hFF02DD04);
      bus1.reset_req = 1'b0; bus1.chipselect = 1'b0; bus1.write = 1'b0;
      cpu_rd1(6'd3, "gated write ignored", 32'h11BB33DD);

      // Deferred swap: request, wait, apply on vsync.
      bus1.swap_req = 1'b1; tick(); bus1.swap_req = 1'b0;
      for (int k = 0; k < 9; k++) begin
         check($sformatf("pending wait%0d", k), {31'd0, bus1.swap_pending}, 32'd1);
         check($sformatf("front hold%0d", k), {31'd0, bus1.front_bank}, 32'd0);
         tick();
      end
      bus1.vsync = 1'b1;
      pix1(6'd3);
      bus1.vsync = 1'b0;
      fb_m = 1;
      check("front after vsync", {31'd0, bus1.front_bank}, 32'd1);
      check("pending after vsync", {31'd0, bus1.swap_pending}, 32'd0);
      pix1(6'd3);
      cpu_rd1(6'd3, "back is bank0", 32'hB0000300);
      tick(); tick(); tick();

      bus1.swap_req = 1'b1; bus1.vsync = 1'b1; tick(); bus1.swap_req = 1'b0; bus1.vsync = 1'b0;
      fb_m = 0;
      check("coincident pending", {31'd0, bus1.swap_pending}, 32'd0);
      check("coincident front", {31'd0, bus1.front_bank}, 32'd0);

      bus1.swap_req = 1'b1; tick(); bus1.swap_req = 1'b0;
      check("double req pending1", {31'd0, bus1.swap_pending}, 32'd1);
      bus1.swap_req = 1'b1; tick(); bus1.swap_req = 1'b0;
      check("double req pending2", {31'd0, bus1.swap_pending}, 32'd1);
      check("double req front", {31'd0, bus1.front_bank}, 32'd0);
      bus1.vsync = 1'b1; tick(); bus1.vsync = 1'b0;
      fb_m = 1;
      check("double req flip", {31'd0, bus1.front_bank}, 32'd1);
      check("double req idle", {31'd0, bus1.swap_pending}, 32'd0);
      tick(); tick();
      check("single flip only", {31'd0, bus1.front_bank}, 32'd1);

      bus1.swap_req = 1'b1; tick(); bus1.swap_req = 1'b0;
      check("pending before reset", {31'd0, bus1.swap_pending}, 32'd1);
      reset = 1'b1; tick(); reset = 1'b0;
      fb_m = 0;
      check("reset drops pending", {31'd0, bus1.swap_pending}, 32'd0);
      check("reset front", {31'd0, bus1.front_bank}, 32'd0);
      check("reset pix_data", bus1.pix_data, 32'd0);
      bus1.vsync = 1'b1; tick(); bus1.vsync = 1'b0;
      check("no flip after reset", {31'd0, bus1.front_bank}, 32'd0);

      // Single-bank build: same-cycle write/lookup collision and inert swap inputs.
      for (int i = 0; i < 64; i++) begin
         bus0.address = 6'(i); bus0.byteenable = 4'hF; bus0.writedata = initval(2, i);
         bus0.chipselect = 1'b1; bus0.write = 1'b1;
         m0[i] = initval(2, i);
         tick();
      end
      bus0.pix_valid = 1'b1; bus0.pix_index = 6'd7;
      q0.push_back('{m0[7], cyc + 2});
      bus0.address = 6'd7; bus0.writedata = 32'h77777777;
      m0[7] = 32'h77777777;
      tick();
      bus0.chipselect = 1'b0; bus0.write = 1'b0;
      q0.push_back('{m0[7], cyc + 2});
      tick();
      bus0.pix_valid = 1'b0;
      bus0.swap_req = 1'b1; tick(); bus0.swap_req = 1'b0;
      check("sb pending", {31'd0, bus0.swap_pending}, 32'd0);
      bus0.vsync = 1'b1; tick(); bus0.vsync = 1'b0;
      check("sb front", {31'd0, bus0.front_bank}, 32'd0);
      bus0.address = 6'd7; bus0.chipselect = 1'b1; tick(); bus0.chipselect = 1'b0;
      check("sb read entry7", bus0.readdata, 32'h77777777);
      bus0.pix_valid = 1'b1; bus0.pix_index = 6'd7;
      q0.push_back('{m0[7], cyc + 2});
      tick();
      bus0.pix_valid = 1'b0;

      repeat (4) tick();
      check("pix1 queue drained", 32'(q1.size()), 32'd0);
      check("pix0 queue drained", 32'(q0.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/palette_lut_dp.md
Name: palette_lut_dp

Overview:
- Parametrised, double-buffered colour palette RAM for the video path.
- CPU side: Avalon-MM slave with byte enables and clock-enable gating. CPU reads and writes always target the back bank.
- Pixel side: a pipelined lookup port that reads the front bank.
- A CPU-requested bank swap is held pending and applied only on a vsync pulse, so palette updates never tear mid-frame.

Parameters:
- DATA_WIDTH, 32, palette entry width in bits; must be a multiple of 8; byte lanes = DATA_WIDTH/8.
- ADDR_WIDTH, 6, entry index width; depth per bank = 2**ADDR_WIDTH.
- DOUBLE_BUFFER, 1, 1 = two banks with swap logic; 0 = single bank, swap inputs ignored, swap_pending and front_bank tied 0.
- INIT_FILE, "palette.mif", initial contents of bank 0; bank 1 uninitialised (X in sim).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_WIDTH  CPU entry index (back bank)
- byteenable  in  DATA_WIDTH/8  CPU write lane enables
- chipselect  in  1  CPU select
- write  in  1  CPU write strobe
- writedata  in  DATA_WIDTH  CPU write data
- readdata  out  DATA_WIDTH  CPU read data
- clken  in  1  CPU-port clock enable
- reset_req  in  1  CPU-port hold request; blocks CPU port
- swap_req  in  1  one-cycle pulse: request front/back exchange
- vsync  in  1  one-cycle pulse at start of vertical blank
- swap_pending  out  1  swap requested, not yet applied
- front_bank  out  1  bank currently used by the pixel port
- pix_valid  in  1  pixel index valid this cycle
- pix_index  in  ADDR_WIDTH  pixel palette index
- pix_data  out  DATA_WIDTH  looked-up palette entry
- pix_data_valid  out  1  pix_data valid

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - Cleared: readdata=0, pix_data=0, pix_data_valid=0, swap_pending=0, front_bank=0, and the pixel pipeline valid bits.
  - Not cleared: RAM contents.
  - A pending swap is discarded.
- CPU port enable:
  - cpu_en = clken & ~reset_req.
  - When cpu_en=0: no write occurs and readdata holds its value.
- CPU write:
  - Occurs when cpu_en & chipselect & write.
  - Byte lane i of entry {back_bank, address} is updated only if byteenable[i]=1.
  - back_bank = ~front_bank; when DOUBLE_BUFFER=0 it is 0.
- CPU read:
  - readdata is registered; it equals the back-bank entry addressed at cycle N and is visible at N+1 (latency 1).
  - It updates on every cpu_en cycle, regardless of chipselect.
  - Read-during-write to the same address returns the OLD data.
- Pixel port:
  - Two-stage pipeline, latency 2. Pixel port is not gated by clken/reset_req.
  - Stage 1 registers RAM[{front_bank, pix_index}] plus a valid bit.
  - Stage 2 registers pix_data and pix_data_valid.
  - pix_data_valid at N+2 = pix_valid at N.
  - When the valid bit is 0, pix_data holds its previous value.
  - Bank is sampled at the stage-1 read, so in-flight lookups complete from the bank they started in.
- Swap FSM (DOUBLE_BUFFER=1), states IDLE and PENDING:
  - IDLE -> PENDING on swap_req & ~vsync.
  - IDLE -> flip front_bank, remain IDLE, on swap_req & vsync in the same cycle.
  - PENDING -> IDLE and flip front_bank on vsync.
  - swap_req while PENDING: ignored (no double flip).
  - swap_pending = (state==PENDING).
  - The flip is visible on front_bank the cycle after the qualifying edge. CPU accesses from that cycle target the new back bank.
- Collision with DOUBLE_BUFFER=0: a pixel read and CPU write to the same entry in the same cycle return the OLD data on the pixel port.
- Address wrap: none needed; indices are full-width. Out-of-range is impossible.
- Implementation:
  - Inferred true dual-port RAM of 2**(ADDR_WIDTH+DOUBLE_BUFFER) words.
  - Port A: CPU, byte-enabled. Port B: pixel, read-only. Single clock.

Test Plan:
- Reset then pix_valid=1 with pix_index=5 for bank 0 preloaded with 0x00FF8040 at entry 5 -> pix_data=0x00FF8040 and pix_data_valid=1 exactly 2 cycles later; readdata=0 after reset.
- CPU writes 0xAABBCCDD to address 3 with byteenable=4'b0101, over prior back-bank value 0x11223344 -> CPU read of address 3 returns 0x11BB33DD one cycle after the read; front-bank entry 3 remains unchanged on the pixel port.
- swap_req at cycle 10, vsync at cycle 20 -> swap_pending=1 during cycles 11..20, front_bank=1 from cycle 21; pixel lookups issued at cycle 21 read the new bank, and a lookup issued at cycle 20 still reads the old bank.
- swap_req and vsync coincident -> swap_pending stays 0 and front_bank toggles next cycle. A second swap_req while PENDING, then one vsync -> exactly one toggle.
- clken=0 or reset_req=1 during a CPU write of 0xDEADBEEF -> entry unchanged and readdata held. reset asserted while PENDING -> swap_pending=0, front_bank=0, and no flip on the following vsync.
- DOUBLE_BUFFER=0 build: CPU write and pixel read of entry 7 in the same cycle -> pix_data shows old value; a pixel read of entry 7 on the next cycle shows new value; swap_req/vsync have no effect.
